// File: rtl/uart_wb_fifo_regs.sv
// Wishbone classic slave exposing the UART register file with byte-wide TX/RX FIFOs,
// sticky overflow flags, programmable wait states and a maskable registered interrupt.
module uart_wb_fifo_regs #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                clock,
  input  logic                WB_RST_I,
  input  logic [ADDR_W-1:0]   WB_ADDR_I,
  input  logic [DATA_W/8-1:0] WB_SEL_I,
  input  logic [DATA_W-1:0]   WB_DAT_I,
  output logic [DATA_W-1:0]   WB_DAT_O,
  input  logic                WB_WE_I,
  input  logic                WB_STB_I,
  input  logic                WB_CYC_I,
  output logic                WB_ACK_O,
  output logic                INT_O,
  output logic [7:0]          TX_DATA_O,
  output logic                TX_VALID_O,
  input  logic                TX_READY_I,
  input  logic [7:0]          RX_DATA_I,
  input  logic                RX_VALID_I
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t     state, state_nxt;
  logic [1:0] wcnt, wcnt_nxt;
  logic       fire;
  logic       req;

  assign req = WB_CYC_I & WB_STB_I;

  always_ff @(posedge clock) begin
    if (WB_RST_I) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // fire marks the single edge that enters ACK; every side effect keys off it
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    fire      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_ACK;
            fire      = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = 2'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (wcnt == 2'd1) begin
          state_nxt = S_ACK;
          fire      = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 2'd1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign WB_ACK_O = (state == S_ACK);

  logic       in_range, wr, rd;
  logic [2:0] idx;
  logic       wr_data, wr_ier, wr_ctrl, wr_scr, rd_data;
  logic       flush_tx, flush_rx, clr_ovf;

  assign in_range = ((WB_ADDR_I >> 3) == '0);
  assign idx      = WB_ADDR_I[2:0];
  assign wr       = fire & WB_WE_I & WB_SEL_I[0] & in_range;
  assign rd       = fire & ~WB_WE_I & in_range;
  assign wr_data  = wr & (idx == 3'd0);
  assign wr_ier   = wr & (idx == 3'd1);
  assign wr_ctrl  = wr & (idx == 3'd3);
  assign wr_scr   = wr & (idx == 3'd4);
  assign rd_data  = rd & (idx == 3'd0);
  assign flush_tx = wr_ctrl & WB_DAT_I[0];
  assign flush_rx = wr_ctrl & WB_DAT_I[1];
  assign clr_ovf  = wr_ctrl & WB_DAT_I[2];

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             tx_ovf_set, rx_ovf_set;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CNT_W'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == CNT_W'(FIFO_DEPTH));

  // a pop on the same edge frees the slot, so a push into a full FIFO is then accepted
  assign tx_pop     = ~tx_empty & TX_READY_I & ~flush_tx;
  assign tx_push    = wr_data & (~tx_full | tx_pop) & ~flush_tx;
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop & ~flush_tx;
  assign rx_pop     = rd_data & ~rx_empty & ~flush_rx;
  assign rx_push    = RX_VALID_I & (~rx_full | rx_pop) & ~flush_rx;
  assign rx_ovf_set = RX_VALID_I & rx_full & ~rx_pop & ~flush_rx;

  always_ff @(posedge clock) begin
    if (!WB_RST_I && tx_push) tx_mem[tx_wp] <= WB_DAT_I[7:0];
    if (!WB_RST_I && rx_push) rx_mem[rx_wp] <= RX_DATA_I;
  end

  always_ff @(posedge clock) begin
    if (WB_RST_I || flush_tx) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_W'(1);
      if (tx_pop)  tx_rp <= tx_rp + PTR_W'(1);
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_W'(1);
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (WB_RST_I || flush_rx) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PTR_W'(1);
      if (rx_pop)  rx_rp <= rx_rp + PTR_W'(1);
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_W'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_W'(1);
    end
  end

  assign TX_VALID_O = ~tx_empty;
  assign TX_DATA_O  = tx_empty ? '0 : tx_mem[tx_rp];

  logic [2:0] ier;
  logic [7:0] scratch;
  logic       tx_ovf, rx_ovf;
  logic [7:0] status, rd_byte;

  assign status = {2'b00, tx_ovf, rx_ovf, rx_full, tx_full, tx_empty, ~rx_empty};

  always_comb begin
    rd_byte = '0;
    if (in_range) begin
      case (idx)
        3'd0:    rd_byte = rx_empty ? '0 : rx_mem[rx_rp];
        3'd1:    rd_byte = {5'b00000, ier};
        3'd2:    rd_byte = status;
        3'd4:    rd_byte = scratch;
        default: rd_byte = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (WB_RST_I) begin
      WB_DAT_O <= '0;
      ier      <= '0;
      scratch  <= '0;
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
      INT_O    <= 1'b0;
    end else begin
      if (fire)   WB_DAT_O <= DATA_W'(rd_byte);
      if (wr_ier) ier      <= WB_DAT_I[2:0];
      if (wr_scr) scratch  <= WB_DAT_I[7:0];
      // a drop on the clearing edge keeps its flag set
      if (tx_ovf_set)   tx_ovf <= 1'b1;
      else if (clr_ovf) tx_ovf <= 1'b0;
      if (rx_ovf_set)   rx_ovf <= 1'b1;
      else if (clr_ovf) rx_ovf <= 1'b0;
      INT_O <= (ier[0] & ~rx_empty) | (ier[1] & tx_empty) | (ier[2] & (rx_ovf | tx_ovf));
    end
  end

  logic unused_bits;
  assign unused_bits = ^{WB_SEL_I, WB_DAT_I};

endmodule

// File: tb/tb_uart_wb_fifo_regs.sv
// Randomised bench for uart_wb_fifo_regs: queue-based register/FIFO model updated once per
// clock edge, outputs compared #1 after every rising edge.
module tb_uart_wb_fifo_regs;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 4;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] adr = '0;
  logic [3:0]    sel = '0;
  logic [31:0]   dat_i = '0;
  logic [31:0]   dat_o;
  logic          we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic          ack, int_o;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;

  uart_wb_fifo_regs #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D), .WAIT_STATES(WS)) dut (
    .clock(clk), .WB_RST_I(rst), .WB_ADDR_I(adr), .WB_SEL_I(sel), .WB_DAT_I(dat_i),
    .WB_DAT_O(dat_o), .WB_WE_I(we), .WB_STB_I(stb), .WB_CYC_I(cyc), .WB_ACK_O(ack),
    .INT_O(int_o), .TX_DATA_O(tx_data), .TX_VALID_O(tx_valid), .TX_READY_I(tx_ready),
    .RX_DATA_I(rx_data), .RX_VALID_I(rx_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [2:0]  m_ier = '0;
  logic [7:0]  m_scr = '0;
  bit          m_rxovf = 0, m_txovf = 0;
  bit          exp_int = 0, exp_ack = 0, exp_rd_chk = 0;
  logic [31:0] exp_rd = '0;
  logic [31:0] rd;

  function automatic logic [7:0] m_status();
    return {2'b00, m_txovf, m_rxovf, (rx_q.size() == D), (tx_q.size() == D),
            (tx_q.size() == 0), (rx_q.size() != 0)};
  endfunction

  task automatic model_edge(input bit fire);
    bit         in_rng, wr, rdp;
    logic [2:0] idx;
    logic [7:0] rb;
    exp_rd_chk = 0;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      m_ier = '0; m_scr = '0; m_rxovf = 0; m_txovf = 0;
      exp_int = 0; exp_ack = 0;
    end else begin
      in_rng = (adr < 8);
      idx    = adr[2:0];
      rb     = '0;
      if (in_rng) begin
        case (idx)
          3'd0: if (rx_q.size() != 0) rb = rx_q[0];
          3'd1: rb = {5'b0, m_ier};
          3'd2: rb = m_status();
          3'd4: rb = m_scr;
          default: rb = '0;
        endcase
      end
      exp_int = (m_ier[0] && rx_q.size() != 0) || (m_ier[1] && tx_q.size() == 0) ||
                (m_ier[2] && (m_rxovf || m_txovf));
      wr  = fire && we && sel[0] && in_rng;
      rdp = fire && !we && in_rng && idx == 3'd0;
      if (wr && idx == 3'd3 && dat_i[2]) begin m_rxovf = 0; m_txovf = 0; end
      if (wr && idx == 3'd3 && dat_i[0]) tx_q.delete();
      else begin
        if (tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
        if (wr && idx == 3'd0) begin
          if (tx_q.size() < D) tx_q.push_back(dat_i[7:0]); else m_txovf = 1;
        end
      end
      if (wr && idx == 3'd3 && dat_i[1]) rx_q.delete();
      else begin
        if (rdp && rx_q.size() != 0) void'(rx_q.pop_front());
        if (rx_valid) begin
          if (rx_q.size() < D) rx_q.push_back(rx_data); else m_rxovf = 1;
        end
      end
      if (wr && idx == 3'd1) m_ier = dat_i[2:0];
      if (wr && idx == 3'd4) m_scr = dat_i[7:0];
      exp_ack    = fire;
      exp_rd_chk = fire && !we;
      exp_rd     = {24'h0, rb};
    end
  endtask

  task automatic tick(input bit fire);
    logic [7:0] head;
    @(posedge clk);
    model_edge(fire);
    #1;
    head = '0;
    if (tx_q.size() != 0) head = tx_q[0];
    check_eq("ack", ack, exp_ack);
    check_eq("tx_valid", tx_valid, tx_q.size() != 0);
    check_eq("tx_data", tx_data, head);
    check_eq("int", int_o, exp_int);
    if (exp_rd_chk) check_eq("rdata", dat_o, exp_rd);
  endtask

  task automatic set_side(input bit rnd);
    if (rnd) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
    end else begin
      rx_valid = 1'b0;
    end
  endtask

  task automatic bus(input bit w, input int a, input logic [3:0] s, input logic [31:0] d,
                     input bit rnd, input bit rx_fire, output logic [31:0] r);
    adr = AW'(a); sel = s; dat_i = d; we = w; cyc = 1'b1; stb = 1'b1;
    r = '0;
    for (int i = 0; i <= WS; i++) begin
      set_side(rnd);
      if (i == WS && rx_fire) begin rx_valid = 1'b1; rx_data = 8'h5A; end
      tick(i == WS);
      if (i == WS) r = dat_o;
    end
    cyc = 1'b0; stb = 1'b0;
    set_side(rnd);
    tick(1'b0);
  endtask

  task automatic wb_write(input int a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, s, d, 1'b0, 1'b0, dummy);
  endtask

  task automatic wb_read(input int a, output logic [31:0] r);
    bus(1'b0, a, 4'hF, 32'h0, 1'b0, 1'b0, r);
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      set_side(rnd);
      tick(1'b0);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick(1'b0);
    rx_valid = 1'b0;
  endtask

  initial begin
    tick(1'b0); tick(1'b0);
    rst = 1'b0;
    check_eq("dat_o_reset", dat_o, 32'h0);

    wb_read(2, rd); check_eq("status_reset", rd, 32'h02);
    wb_read(0, rd); check_eq("data_empty", rd, 32'h00);
    wb_read(2, rd); check_eq("status_no_pop", rd, 32'h02);

    wb_write(0, 4'h1, 32'hA5);
    idle(1, 0);
    check_eq("txv_after_wr", tx_valid, 1'b1);
    check_eq("txd_after_wr", tx_data, 8'hA5);
    tx_ready = 1'b1; idle(1, 0); tx_ready = 1'b0;
    check_eq("txv_after_pop", tx_valid, 1'b0);

    for (int i = 0; i <= D; i++) rx_byte(8'(8'h10 + i));
    wb_read(2, rd); check_eq("status_rx_ovf", rd, 32'h1B);
    for (int i = 0; i < D; i++) begin
      wb_read(0, rd); check_eq("rx_order", rd, 32'(8'h10 + i));
    end
    wb_read(2, rd); check_eq("status_drained", rd, 32'h12);
    wb_write(3, 4'h1, 32'h04);
    wb_read(2, rd); check_eq("status_ovf_clr", rd, 32'h02);

    wb_write(1, 4'h1, 32'h01);
    rx_byte(8'h3C);
    check_eq("int_lag", int_o, 1'b0);
    idle(1, 0);
    check_eq("int_rise", int_o, 1'b1);
    wb_read(0, rd); check_eq("rx_3c", rd, 32'h3C);
    check_eq("int_fall", int_o, 1'b0);
    wb_write(1, 4'h1, 32'h00);

    wb_write(0, 4'hE, 32'h12345678);
    idle(1, 0); check_eq("sel_no_push", tx_valid, 1'b0);
    wb_write(0, 4'h1, 32'h12345678);
    idle(1, 0); check_eq("sel_push", tx_data, 8'h78);
    tx_ready = 1'b1; idle(1, 0); tx_ready = 1'b0;
    wb_write(4, 4'hF, 32'hFFFFFFFF);
    wb_read(4, rd); check_eq("scratch_lanes", rd, 32'h000000FF);
    wb_write(12, 4'hF, 32'h00000000);
    wb_read(12, rd); check_eq("oob_read", rd, 32'h0);
    wb_read(5, rd);  check_eq("addr5_read", rd, 32'h0);
    wb_read(4, rd);  check_eq("scratch_kept", rd, 32'h000000FF);

    rx_byte(8'h77);
    adr = '0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    tick(1'b0);
    stb = 1'b0;
    tick(1'b0);
    cyc = 1'b0;
    idle(2, 0);
    wb_read(2, rd); check_eq("status_abort", rd, 32'h03);
    wb_read(0, rd); check_eq("rx_after_abort", rd, 32'h77);

    wb_write(0, 4'h1, 32'h11);
    wb_write(0, 4'h1, 32'h22);
    rx_byte(8'h01); rx_byte(8'h02);
    bus(1'b1, 3, 4'h1, 32'h03, 1'b0, 1'b1, rd);
    wb_read(2, rd); check_eq("status_flush", rd, 32'h02);

    rx_byte(8'h99);
    adr = '0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    tick(1'b0); tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick(1'b0);
    wb_read(2, rd); check_eq("status_mid_rst", rd, 32'h02);
    wb_read(4, rd); check_eq("scratch_mid_rst", rd, 32'h00);

    for (int n = 0; n < 400; n++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(0, 4));
      bus(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 1'b1, 1'b0, rd);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
